// File: rtl/hd44780_rx.sv
// rtl/hd44780_rx.sv - HD44780 4/8-bit bus responder: nibble assembly, instruction decode, DDRAM write port
module hd44780_rx #(
    parameter int CMD_CYCLES   = 10,
    parameter int CLEAR_CYCLES = 400
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       e,
    input  logic       rs,
    input  logic [3:0] db,
    output logic       busy,
    output logic       err,
    output logic       mode4,
    output logic [6:0] ac,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       lines2,
    output logic       inc,
    output logic       wr_en,
    output logic [6:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       instr_valid,
    output logic [7:0] instr,
    output logic       instr_rs
);
    // The clear fill alone needs EXEC plus 128 write cycles, so clear busy never ends earlier.
    localparam int CLR_EFF = (CLEAR_CYCLES > 129) ? CLEAR_CYCLES : 129;
    localparam int BMAX    = (CLR_EFF > CMD_CYCLES) ? CLR_EFF : CMD_CYCLES;
    localparam int CW      = $clog2(BMAX + 1);
    localparam logic [CW-1:0] CMD_LOAD = CW'(CMD_CYCLES - 1);
    localparam logic [CW-1:0] CLR_LOAD = CW'(CLR_EFF - 1);

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_EXEC       = 2'd1;
    localparam logic [1:0] S_CLEAR_FILL = 2'd2;
    localparam logic [1:0] S_WAIT       = 2'd3;

    logic          e_s1, e_s2, e_s3;
    logic          rs_s1, rs_s2;
    logic [3:0]    db_s1, db_s2;
    logic          stb, stb_rs;
    logic [3:0]    stb_db;
    logic          phase_lo;
    logic [3:0]    hi_nib;
    logic          cg_sel;
    logic [1:0]    state;
    logic [CW-1:0] cnt;

    function automatic logic [6:0] step(input logic [6:0] a, input logic up, input logic two);
        logic [6:0] r;
        r = up ? a + 7'd1 : a - 7'd1;
        if (two) begin
            if (up && a == 7'h27)       r = 7'h40;
            else if (up && a == 7'h67)  r = 7'h00;
            else if (!up && a == 7'h40) r = 7'h27;
            else if (!up && a == 7'h00) r = 7'h67;
        end else begin
            if (up && a == 7'h4F)       r = 7'h00;
            else if (!up && a == 7'h00) r = 7'h4F;
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_s1 <= 1'b0; e_s2 <= 1'b0; e_s3 <= 1'b0;
            rs_s1 <= 1'b0; rs_s2 <= 1'b0;
            db_s1 <= 4'd0; db_s2 <= 4'd0;
            stb <= 1'b0; stb_rs <= 1'b0; stb_db <= 4'd0;
            phase_lo <= 1'b0; hi_nib <= 4'd0; cg_sel <= 1'b0;
            state <= S_IDLE; cnt <= '0;
            busy <= 1'b0; err <= 1'b0; mode4 <= 1'b0; ac <= 7'd0;
            disp_on <= 1'b0; cursor_on <= 1'b0; blink_on <= 1'b0;
            lines2 <= 1'b0; inc <= 1'b1;
            wr_en <= 1'b0; wr_addr <= 7'd0; wr_data <= 8'd0;
            instr_valid <= 1'b0; instr <= 8'd0; instr_rs <= 1'b0;
        end else begin
            e_s1  <= e;   e_s2  <= e_s1;  e_s3 <= e_s2;
            rs_s1 <= rs;  rs_s2 <= rs_s1;
            db_s1 <= db;  db_s2 <= db_s1;
            stb    <= e_s3 & ~e_s2;
            stb_rs <= rs_s2;
            stb_db <= db_s2;

            instr_valid <= 1'b0;
            wr_en       <= 1'b0;

            if (stb) begin
                if (busy) begin
                    err <= 1'b1;
                end else if (mode4 && !phase_lo) begin
                    hi_nib   <= stb_db;
                    phase_lo <= 1'b1;
                end else begin
                    instr_valid <= 1'b1;
                    instr       <= mode4 ? {hi_nib, stb_db} : {stb_db, 4'b0000};
                    instr_rs    <= stb_rs;
                    phase_lo    <= 1'b0;
                end
            end

            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        state <= S_EXEC;
                        busy  <= 1'b1;
                        cnt   <= CMD_LOAD;
                        if (instr_rs) begin
                            if (!cg_sel) begin
                                wr_en   <= 1'b1;
                                wr_addr <= ac;
                                wr_data <= instr;
                                ac      <= step(ac, inc, lines2);
                            end
                        end else begin
                            casez (instr)
                                8'b1???????: begin ac <= instr[6:0]; cg_sel <= 1'b0; end
                                8'b01??????: cg_sel <= 1'b1;
                                8'b001?????: begin
                                    lines2 <= instr[3];
                                    mode4  <= ~instr[4];
                                    if (!instr[4]) phase_lo <= 1'b0;
                                end
                                8'b0001????: if (!instr[3]) ac <= step(ac, instr[2], lines2);
                                8'b00001???: begin
                                    disp_on   <= instr[2];
                                    cursor_on <= instr[1];
                                    blink_on  <= instr[0];
                                end
                                8'b000001??: inc <= instr[1];
                                8'b0000001?: begin ac <= 7'd0; cnt <= CLR_LOAD; end
                                8'b00000001: begin ac <= 7'd0; inc <= 1'b1; cnt <= CLR_LOAD; end
                                default: ;
                            endcase
                        end
                    end
                end
                S_EXEC, S_CLEAR_FILL, S_WAIT: begin
                    if (state == S_EXEC && !instr_rs && instr == 8'h01) begin
                        state   <= S_CLEAR_FILL;
                        wr_en   <= 1'b1;
                        wr_addr <= 7'd0;
                        wr_data <= 8'h20;
                        cnt     <= cnt - CW'(1);
                    end else if (state == S_CLEAR_FILL && wr_addr != 7'h7F) begin
                        wr_en   <= 1'b1;
                        wr_addr <= wr_addr + 7'd1;
                        cnt     <= cnt - CW'(1);
                    end else if (cnt == '0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= S_WAIT;
                        cnt   <= cnt - CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hd44780_rx.sv
// tb/tb_hd44780_rx.sv - directed bench for hd44780_rx with a transaction-level LCD model
module tb_hd44780_rx;
    localparam int CMDC = 10;
    localparam int CLRC = 400;
    localparam int CLR_BUSY = (CLRC > 129) ? CLRC : 129;

    logic       clk = 1'b0;
    logic       rst, e, rs;
    logic [3:0] db;
    logic       busy, err, mode4, disp_on, cursor_on, blink_on, lines2, inc;
    logic       wr_en, instr_valid, instr_rs;
    logic [6:0] ac, wr_addr;
    logic [7:0] wr_data, instr;

    hd44780_rx #(.CMD_CYCLES(CMDC), .CLEAR_CYCLES(CLRC)) dut (
        .clk(clk), .rst(rst), .e(e), .rs(rs), .db(db),
        .busy(busy), .err(err), .mode4(mode4), .ac(ac),
        .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
        .lines2(lines2), .inc(inc),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .instr_valid(instr_valid), .instr(instr), .instr_rs(instr_rs)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int n_wr  = 0;
    bit run   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Model state: what the LCD must hold after each host strobe.
    bit       m_mode4, m_phase_hi, m_lines2, m_inc, m_disp, m_cur, m_blk, m_cg, m_err;
    logic [3:0] m_hi;
    logic [6:0] m_ac;

    typedef struct {logic [7:0] b; logic r; int fall;} ib_t;
    ib_t         exp_i[$];
    logic [14:0] exp_w[$];
    int          exp_busy[$];

    task automatic model_reset();
        m_mode4 = 0; m_phase_hi = 1; m_lines2 = 0; m_inc = 1;
        m_disp = 0; m_cur = 0; m_blk = 0; m_cg = 0; m_err = 0;
        m_hi = 4'd0; m_ac = 7'd0;
        exp_i.delete(); exp_w.delete(); exp_busy.delete();
    endtask

    // Addresses on the visible lines form one ring of 80 cells; anything else steps plain mod 128.
    function automatic logic [6:0] m_step(input logic [6:0] a, input bit up);
        int  idx;
        bit  in_rng;
        if (m_lines2) begin
            in_rng = (a <= 7'h27) || (a >= 7'h40 && a <= 7'h67);
            idx    = (a >= 7'h40) ? int'(a) - 64 + 40 : int'(a);
        end else begin
            in_rng = (a <= 7'h4F);
            idx    = int'(a);
        end
        if (!in_rng) return up ? 7'(int'(a) + 1) : 7'(int'(a) - 1);
        idx = up ? (idx + 1) % 80 : (idx + 79) % 80;
        if (m_lines2 && idx >= 40) return 7'(idx - 40 + 64);
        return 7'(idx);
    endfunction

    task automatic model_apply(input logic [7:0] b, input bit r, input int fall);
        exp_i.push_back('{b, r, fall});
        exp_busy.push_back((!r && (b == 8'h01 || b == 8'h02 || b == 8'h03)) ? CLR_BUSY : CMDC);
        if (r) begin
            if (!m_cg) begin
                exp_w.push_back({m_ac, b});
                m_ac = m_step(m_ac, m_inc);
            end
        end else if (b[7]) begin m_ac = b[6:0]; m_cg = 0; end
        else if (b[6]) m_cg = 1;
        else if (b[5]) begin m_lines2 = b[3]; m_mode4 = !b[4]; if (!b[4]) m_phase_hi = 1; end
        else if (b[4]) begin if (!b[3]) m_ac = m_step(m_ac, b[2]); end
        else if (b[3]) begin m_disp = b[2]; m_cur = b[1]; m_blk = b[0]; end
        else if (b[2]) m_inc = b[1];
        else if (b[1]) m_ac = 7'd0;
        else if (b[0]) begin
            m_ac = 7'd0; m_inc = 1;
            for (int i = 0; i < 128; i++) exp_w.push_back({7'(i), 8'h20});
        end
    endtask

    task automatic nibble(input bit r, input logic [3:0] d, input bit viol, input int post);
        @(negedge clk);
        rs = r; db = d; e = 1'b1;
        repeat (4) @(negedge clk);
        e = 1'b0;
        if (viol) m_err = 1;
        else if (m_mode4 && m_phase_hi) begin m_hi = d; m_phase_hi = 0; end
        else begin
            m_phase_hi = 1;
            model_apply(m_mode4 ? {m_hi, d} : {d, 4'b0000}, r, cyc);
        end
        repeat (post) @(negedge clk);
    endtask

    task automatic send(input bit r, input logic [7:0] b, input int gap);
        nibble(r, b[7:4], 0, 0);
        repeat (3) @(negedge clk);
        nibble(r, b[3:0], 0, gap);
    endtask

    task automatic check_state(input string t);
        chk({t, ".ac"}, ac, m_ac);
        chk({t, ".mode4"}, mode4, m_mode4);
        chk({t, ".lines2"}, lines2, m_lines2);
        chk({t, ".inc"}, inc, m_inc);
        chk({t, ".dcb"}, {disp_on, cursor_on, blink_on}, {m_disp, m_cur, m_blk});
        chk({t, ".err"}, err, m_err);
        chk({t, ".busy"}, busy, 0);
    endtask

    // Compare process: every write, completed byte and busy window against the model queues.
    int blen = 0;
    always @(negedge clk) begin
        if (rst) begin
            blen = 0;
        end else if (run) begin
            if (wr_en) begin
                n_wr++;
                if (exp_w.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", wr_addr, wr_data);
                end else chk("write", {wr_addr, wr_data}, exp_w.pop_front());
            end
            if (instr_valid) begin
                if (exp_i.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_byte: got 0x%0h expected none", instr);
                end else begin
                    ib_t x;
                    x = exp_i.pop_front();
                    chk("byte", {instr_rs, instr}, {x.r, x.b});
                    chk("byte_latency", cyc - x.fall, 4);
                end
            end
            if (busy) blen++;
            else if (blen > 0) begin
                if (exp_busy.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_busy: got %0d cycles expected none", blen);
                end else chk("busy_len", blen, exp_busy.pop_front());
                blen = 0;
            end
        end
    end

    initial begin
        bit found;
        int nw0;
        rst = 1'b1; e = 1'b0; rs = 1'b0; db = 4'd0;
        model_reset();
        #12;
        chk("reset.outs", {busy, err, mode4, ac, disp_on, cursor_on, blink_on, lines2, wr_en,
                           wr_addr, wr_data, instr_valid, instr, instr_rs}, 0);
        chk("reset.inc", inc, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run = 1;

        // Driver init sequence
        nibble(0, 4'h2, 0, 500);
        chk("init.mode4_early", mode4, 1);
        send(0, 8'h28, 500);
        send(0, 8'h01, 500);
        send(0, 8'h0E, 500);
        send(0, 8'h06, 500);
        check_state("init");
        chk("init.lit", {mode4, lines2, disp_on, cursor_on, blink_on, inc, err}, 7'b1111010);
        chk("init.clear_writes", n_wr, 128);

        // Data write
        send(0, 8'h80, 20);
        send(1, 8'h48, 20);
        send(1, 8'h69, 20);
        check_state("data");
        chk("data.ac", ac, 7'h02);
        chk("data.last", {instr_rs, instr}, 9'h169);

        // Line wrap, incrementing
        send(0, 8'hA7, 20);
        send(1, 8'h55, 20);
        chk("wrap1.ac", ac, 7'h40);
        send(0, 8'hE7, 20);
        send(1, 8'h56, 20);
        chk("wrap2.ac", ac, 7'h00);
        check_state("wrap");

        // Line wrap, decrementing
        send(0, 8'h04, 20);
        send(0, 8'hC0, 20);
        send(1, 8'h57, 20);
        chk("dec.ac", ac, 7'h27);
        check_state("dec");

        // Cursor shift, CGRAM select, return home
        send(0, 8'h14, 20);
        chk("shr.ac", ac, 7'h40);
        send(0, 8'h10, 20);
        send(0, 8'h18, 20);
        chk("shl_sc.ac", ac, 7'h27);
        send(0, 8'h40, 20);
        send(1, 8'h77, 20);
        chk("cg.ac", ac, 7'h27);
        send(0, 8'h02, 500);
        chk("home.ac", ac, 7'h00);
        send(0, 8'h80, 20);
        check_state("misc");

        // Busy violation: third strobe falls 3 cycles after EXEC of the 0x41 data byte
        nibble(1, 4'h4, 0, 0);
        repeat (3) @(negedge clk);
        nibble(1, 4'h1, 0, 0);
        repeat (3) @(negedge clk);
        nibble(1, 4'h5, 1, 20);
        chk("viol.err", err, 1);
        send(1, 8'h42, 20);
        chk("viol.ac", ac, 7'h66);
        check_state("viol");
        chk("queues_drained", exp_w.size() + exp_i.size() + exp_busy.size(), 0);

        // Reset in the middle of the clear fill
        send(0, 8'h01, 0);
        found = 0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (wr_en && wr_addr == 7'd50) found = 1;
        end
        chk("midclear.reached50", found, 1);
        #2 rst = 1'b1;
        #1;
        chk("midclear.outs", {busy, err, mode4, ac, disp_on, cursor_on, blink_on, lines2, wr_en,
                              wr_addr, wr_data, instr_valid, instr, instr_rs}, 0);
        chk("midclear.inc", inc, 1);
        model_reset();
        nw0 = n_wr;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        chk("midclear.no_writes", n_wr - nw0, 0);
        check_state("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
